// File: rtl/hdu_pkg.sv
// Shared types and helpers for the multi-way hazard unit: FSM states,
// scoreboard counter width and the rotating-age comparison.
package hdu_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int SB_CNT_W       = 3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hdu_state_t;

    // True when way i is strictly older than way j, with age increasing
    // modulo num_ways from the oldest slot.
    function automatic logic older(input int i, input int j, input int oldest, input int num_ways);
        int age_i;
        int age_j;
        age_i = (i - oldest + num_ways) % num_ways;
        age_j = (j - oldest + num_ways) % num_ways;
        return age_i < age_j;
    endfunction

endpackage

// File: rtl/multi_way_hazard_unit_scoreboard.sv
// Per-register load latency scoreboard: one down-counter per architectural
// register (register 0 never busy) with two busy read ports per issue way.
module hdu_scoreboard
    import hdu_pkg::*;
#(
    parameter int NUM_WAYS   = 2,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_LAT   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_WAYS-1:0]            set_en,
    input  logic [NUM_WAYS*REG_ADDR_W-1:0] set_dst,
    input  logic [NUM_WAYS*REG_ADDR_W-1:0] rd_rs,
    input  logic [NUM_WAYS*REG_ADDR_W-1:0] rd_rt,
    output logic [NUM_WAYS-1:0]            rs_busy,
    output logic [NUM_WAYS-1:0]            rt_busy
);

    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam logic [SB_CNT_W-1:0] LAT = SB_CNT_W'(LOAD_LAT);

    logic [SB_CNT_W-1:0] cnt_reg  [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_next [NUM_REGS];

    // A new load destination overrides the running decrement.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next[r] = (cnt_reg[r] != '0) ? cnt_reg[r] - 1'b1 : '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (set_en[w] && (set_dst[w*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
                    cnt_next[r] = LAT;
                end
            end
        end
        cnt_next[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_reg[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_reg[r] <= cnt_next[r];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_rd
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        assign rs = rd_rs[gi*REG_ADDR_W +: REG_ADDR_W];
        assign rt = rd_rt[gi*REG_ADDR_W +: REG_ADDR_W];
        assign rs_busy[gi] = (rs != '0) && (cnt_reg[rs] != '0);
        assign rt_busy[gi] = (rt != '0) && (cnt_reg[rt] != '0);
    end

endmodule

// File: rtl/multi_way_hazard_unit.sv
// N-way in-order issue hazard unit with load scoreboard, rotating-age RAW
// check and redirect flush FSM. Define HDU_PERF_CNT_EN for stall/flush counters.
module multi_way_hazard_unit
    import hdu_pkg::*;
#(
    parameter int NUM_WAYS    = 2,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_EXTRA = 1,
    localparam int OLD_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_WAYS-1:0]            id_valid,
    input  logic [NUM_WAYS*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_WAYS*REG_ADDR_W-1:0] id_rt,
    input  logic [NUM_WAYS*REG_ADDR_W-1:0] id_dst,
    input  logic [NUM_WAYS-1:0]            id_wr_en,
    input  logic [NUM_WAYS-1:0]            id_is_load,
    input  logic [OLD_W-1:0]               id_oldest,
    input  logic [NUM_WAYS-1:0]            way_busy,
    input  logic                           redirect,
    output logic                           pc_write,
    output logic [NUM_WAYS-1:0]            issue_ok,
    output logic [NUM_WAYS-1:0]            hazard,
    output logic [NUM_WAYS-1:0]            flush,
    output logic [31:0]                    perf_stall_cnt,
    output logic [31:0]                    perf_flush_cnt
);

    localparam logic [2:0] FLUSH_RELOAD = (FLUSH_EXTRA > 0) ? 3'(FLUSH_EXTRA - 1) : 3'd0;

    hdu_state_t state_reg, state_next;
    logic [2:0] flush_cnt_reg, flush_cnt_next;

    logic [NUM_WAYS-1:0] rs_busy, rt_busy, own_haz, issue_run, set_en;
    logic                flushing;
    int                  oldest_int;

    always_comb begin
        oldest_int = (int'(id_oldest) >= NUM_WAYS) ? 0 : int'(id_oldest);
    end

    hdu_scoreboard #(
        .NUM_WAYS   (NUM_WAYS),
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_LAT   (LOAD_LAT)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (set_en),
        .set_dst (id_dst),
        .rd_rs   (id_rs),
        .rd_rt   (id_rt),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy)
    );

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        logic raw;
        always_comb begin
            raw = 1'b0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (older(i, gi, oldest_int, NUM_WAYS) && id_valid[i] && id_wr_en[i]
                    && (id_dst[i*REG_ADDR_W +: REG_ADDR_W] != '0)
                    && ((id_dst[i*REG_ADDR_W +: REG_ADDR_W] == id_rs[gi*REG_ADDR_W +: REG_ADDR_W])
                     || (id_dst[i*REG_ADDR_W +: REG_ADDR_W] == id_rt[gi*REG_ADDR_W +: REG_ADDR_W]))) begin
                    raw = 1'b1;
                end
            end
            own_haz[gi] = id_valid[gi] & (way_busy[gi] | rs_busy[gi] | rt_busy[gi] | raw);
        end

        // Flushed ways never reach issue_ok, so killed loads cannot mark the scoreboard.
        assign set_en[gi] = issue_ok[gi] & id_is_load[gi] & id_wr_en[gi]
                          & (id_dst[gi*REG_ADDR_W +: REG_ADDR_W] != '0);
    end

    // Walk ways youngest-last; the first held valid way blocks everything younger.
    always_comb begin
        logic blocked;
        int   w;
        blocked   = 1'b0;
        issue_run = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            w = (oldest_int + k) % NUM_WAYS;
            if (id_valid[w]) begin
                if (!own_haz[w] && !blocked) begin
                    issue_run[w] = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_comb begin
        flushing = redirect | (state_reg == FLUSH);
        issue_ok = flushing ? '0 : issue_run;
        hazard   = flushing ? '0 : (id_valid & ~issue_run);
        flush    = flushing ? '1 : '0;
        pc_write = flushing | ~(|(id_valid & ~issue_run));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            flush_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            RUN: begin
                if (redirect && (FLUSH_EXTRA > 0)) begin
                    state_next     = FLUSH;
                    flush_cnt_next = FLUSH_RELOAD;
                end
            end
            FLUSH: begin
                if (redirect) begin
                    flush_cnt_next = FLUSH_RELOAD;
                end else if (flush_cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

`ifdef HDU_PERF_CNT_EN
    logic [31:0] stall_cnt_reg, flush_evt_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg     <= '0;
            flush_evt_cnt_reg <= '0;
        end else begin
            if ((state_reg == RUN) && !pc_write && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if ((|flush) && (flush_evt_cnt_reg != '1)) begin
                flush_evt_cnt_reg <= flush_evt_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_reg;
    assign perf_flush_cnt = flush_evt_cnt_reg;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_way_hazard_unit.sv
// Directed checks of the hazard unit: a 2-way instance (LOAD_LAT=1, FLUSH_EXTRA=2)
// and a 4-way instance (LOAD_LAT=3, FLUSH_EXTRA=1).
module tb_multi_way_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // 2-way instance
    logic        a_rst_n;
    logic [1:0]  a_valid, a_wr, a_ld, a_busy, a_iss, a_haz, a_fl;
    logic [9:0]  a_rs, a_rt, a_dst;
    logic        a_oldest, a_redir, a_pcw;
    logic [31:0] a_ps, a_pf;

    // 4-way instance
    logic        b_rst_n;
    logic [3:0]  b_valid, b_wr, b_ld, b_busy, b_iss, b_haz, b_fl;
    logic [19:0] b_rs, b_rt, b_dst;
    logic [1:0]  b_oldest;
    logic        b_redir, b_pcw;
    logic [31:0] b_ps, b_pf;

    logic [31:0] exp_stall, exp_flush;

    multi_way_hazard_unit #(
        .NUM_WAYS(2), .REG_ADDR_W(5), .LOAD_LAT(1), .FLUSH_EXTRA(2)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .id_valid(a_valid), .id_rs(a_rs), .id_rt(a_rt),
        .id_dst(a_dst), .id_wr_en(a_wr), .id_is_load(a_ld), .id_oldest(a_oldest),
        .way_busy(a_busy), .redirect(a_redir), .pc_write(a_pcw), .issue_ok(a_iss),
        .hazard(a_haz), .flush(a_fl), .perf_stall_cnt(a_ps), .perf_flush_cnt(a_pf)
    );

    multi_way_hazard_unit #(
        .NUM_WAYS(4), .REG_ADDR_W(5), .LOAD_LAT(3), .FLUSH_EXTRA(1)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .id_valid(b_valid), .id_rs(b_rs), .id_rt(b_rt),
        .id_dst(b_dst), .id_wr_en(b_wr), .id_is_load(b_ld), .id_oldest(b_oldest),
        .way_busy(b_busy), .redirect(b_redir), .pc_write(b_pcw), .issue_ok(b_iss),
        .hazard(b_haz), .flush(b_fl), .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_a(input int w, input logic v, input int rs, input int rt,
                         input int dst, input logic wr, input logic ld);
        a_valid[w]       = v;
        a_rs[w*5 +: 5]   = 5'(rs);
        a_rt[w*5 +: 5]   = 5'(rt);
        a_dst[w*5 +: 5]  = 5'(dst);
        a_wr[w]          = wr;
        a_ld[w]          = ld;
    endtask

    task automatic set_b(input int w, input logic v, input int rs, input int rt,
                         input int dst, input logic wr, input logic ld);
        b_valid[w]       = v;
        b_rs[w*5 +: 5]   = 5'(rs);
        b_rt[w*5 +: 5]   = 5'(rt);
        b_dst[w*5 +: 5]  = 5'(dst);
        b_wr[w]          = wr;
        b_ld[w]          = ld;
    endtask

    task automatic clear_a();
        a_valid = '0; a_rs = '0; a_rt = '0; a_dst = '0; a_wr = '0; a_ld = '0;
    endtask

    task automatic clear_b();
        b_valid = '0; b_rs = '0; b_rt = '0; b_dst = '0; b_wr = '0; b_ld = '0;
    endtask

    initial begin
`ifdef HDU_PERF_CNT_EN
        exp_stall = 32'd5;
        exp_flush = 32'd3;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        clear_a(); clear_b();
        a_oldest = 1'b0; a_busy = '0; a_redir = 1'b0;
        b_oldest = 2'd0; b_busy = '0; b_redir = 1'b0;

        // Reset: outputs follow the combinational equations
        set_a(0, 1'b1, 1, 2, 3, 1'b1, 1'b0);
        set_a(1, 1'b1, 4, 5, 6, 1'b1, 1'b0);
        #2;
        check_eq("rst_issue_ok", 32'(a_iss), 32'h3);
        check_eq("rst_flush",    32'(a_fl),  32'h0);
        check_eq("rst_pc_write", 32'(a_pcw), 32'h1);
        check_eq("rst_perf_stall", a_ps, 32'h0);
        check_eq("rst_perf_flush", a_pf, 32'h0);
        next_cycle();
        next_cycle();
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Load-use: lw r5 then add r6,r5,r1
        next_cycle();
        clear_a();
        set_a(0, 1'b1, 1, 0, 5, 1'b1, 1'b1);
        sample();
        check_eq("lu_lw_issue", 32'(a_iss), 32'h1);
        next_cycle();
        set_a(0, 1'b1, 5, 1, 6, 1'b1, 1'b0);
        sample();
        check_eq("lu_hazard",   32'(a_haz), 32'h1);
        check_eq("lu_pc_write", 32'(a_pcw), 32'h0);
        check_eq("lu_held",     32'(a_iss), 32'h0);
        next_cycle();
        sample();
        check_eq("lu_issue_late", 32'(a_iss), 32'h1);
        check_eq("lu_pc_resume",  32'(a_pcw), 32'h1);

        // Intra-group RAW: way1 writes r3 / reads r8, way0 writes r8 / reads r3
        next_cycle();
        a_oldest = 1'b1;
        set_a(1, 1'b1, 8, 0, 3, 1'b1, 1'b0);
        set_a(0, 1'b1, 3, 4, 8, 1'b1, 1'b0);
        sample();
        check_eq("raw_old1_issue",  32'(a_iss), 32'h2);
        check_eq("raw_old1_hazard", 32'(a_haz), 32'h1);
        check_eq("raw_old1_pcw",    32'(a_pcw), 32'h0);
        next_cycle();
        a_oldest = 1'b0;
        sample();
        check_eq("raw_old0_issue",  32'(a_iss), 32'h1);
        check_eq("raw_old0_hazard", 32'(a_haz), 32'h2);

        // Redirect over an active hazard, FLUSH_EXTRA=2
        next_cycle();
        clear_a();
        set_a(0, 1'b1, 1, 2, 3, 1'b1, 1'b0);
        a_busy = 2'b01;
        sample();
        check_eq("rd_pre_hazard", 32'(a_haz), 32'h1);
        next_cycle();
        a_redir = 1'b1;
        sample();
        check_eq("rd_t0_flush",  32'(a_fl),  32'h3);
        check_eq("rd_t0_issue",  32'(a_iss), 32'h0);
        check_eq("rd_t0_hazard", 32'(a_haz), 32'h0);
        check_eq("rd_t0_pcw",    32'(a_pcw), 32'h1);
        next_cycle();
        a_redir = 1'b0;
        sample();
        check_eq("rd_t1_flush", 32'(a_fl),  32'h3);
        check_eq("rd_t1_pcw",   32'(a_pcw), 32'h1);
        next_cycle();
        sample();
        check_eq("rd_t2_flush", 32'(a_fl), 32'h3);
        next_cycle();
        sample();
        check_eq("rd_t3_flush",  32'(a_fl),  32'h0);
        check_eq("rd_t3_hazard", 32'(a_haz), 32'h1);

        // Back-to-back redirect extends flush; flushed lw r9 must not mark r9
        next_cycle();
        a_busy = '0;
        clear_a();
        set_a(0, 1'b1, 1, 2, 9, 1'b1, 1'b1);
        a_redir = 1'b1;
        sample();
        check_eq("rd2_t0_flush", 32'(a_fl), 32'h3);
        next_cycle();
        sample();
        check_eq("rd2_t1_flush", 32'(a_fl), 32'h3);
        next_cycle();
        a_redir = 1'b0;
        sample();
        check_eq("rd2_t2_flush", 32'(a_fl), 32'h3);
        next_cycle();
        sample();
        check_eq("rd2_t3_flush", 32'(a_fl),  32'h3);
        check_eq("rd2_t3_issue", 32'(a_iss), 32'h0);
        next_cycle();
        set_a(0, 1'b1, 9, 0, 10, 1'b1, 1'b0);
        sample();
        check_eq("rd2_t4_flush",    32'(a_fl),  32'h0);
        check_eq("rd2_t4_r9_issue", 32'(a_iss), 32'h1);

        // Perf counters: 5 stall cycles then a 3-cycle flush
        next_cycle();
        a_rst_n = 1'b0;
        clear_a();
        next_cycle();
        a_rst_n = 1'b1;
        set_a(0, 1'b1, 1, 2, 3, 1'b1, 1'b0);
        a_busy = 2'b01;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
        end
        next_cycle();
        a_redir = 1'b1;
        next_cycle();
        a_redir = 1'b0;
        next_cycle();
        next_cycle();
        clear_a();
        a_busy = '0;
        sample();
        check_eq("perf_stall", a_ps, exp_stall);
        check_eq("perf_flush", a_pf, exp_flush);

        // 4-way in-order block behind a busy way
        next_cycle();
        for (int w = 0; w < 4; w++) begin
            set_b(w, 1'b1, 10 + w, 20 + w, 1 + w, 1'b1, 1'b0);
        end
        b_busy = 4'b0010;
        b_oldest = 2'd0;
        sample();
        check_eq("io_old0_issue",  32'(b_iss), 32'h1);
        check_eq("io_old0_hazard", 32'(b_haz), 32'hE);
        check_eq("io_old0_pcw",    32'(b_pcw), 32'h0);
        next_cycle();
        b_oldest = 2'd2;
        sample();
        check_eq("io_old2_issue",  32'(b_iss), 32'hD);
        check_eq("io_old2_hazard", 32'(b_haz), 32'h2);

        // Reset mid-operation clears the LOAD_LAT=3 scoreboard entry
        next_cycle();
        clear_b();
        b_busy = '0;
        b_oldest = 2'd0;
        set_b(0, 1'b1, 1, 0, 7, 1'b1, 1'b1);
        sample();
        check_eq("rs_lw_issue", 32'(b_iss), 32'h1);
        next_cycle();
        set_b(0, 1'b1, 7, 2, 11, 1'b1, 1'b0);
        sample();
        check_eq("rs_r7_hazard", 32'(b_haz), 32'h1);
        #1;
        b_rst_n = 1'b0;
        #1;
        check_eq("rs_async_issue", 32'(b_iss), 32'h1);
        next_cycle();
        b_rst_n = 1'b1;
        sample();
        check_eq("rs_after_issue", 32'(b_iss), 32'h1);
        check_eq("rs_after_pcw",   32'(b_pcw), 32'h1);
        check_eq("rs_after_flush", 32'(b_fl),  32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_way_hazard_unit.md
Name: multi_way_hazard_unit

Overview:
- Parametrised N-way in-order issue hazard unit; successor to the fixed 2-way combinational HDU.
- Sits between the ID group register and EX issue.
- Tracks in-flight loads in a per-register latency scoreboard and resolves intra-group RAW hazards by a rotating age pointer.
- Enforces in-order partial issue and sequences branch/JR redirect flushes with a small FSM.

Parameters:
- NUM_WAYS, 2, issue width (1..4).
- REG_ADDR_W, 5, architectural register index width; register 0 never hazards.
- LOAD_LAT, 1, cycles a load destination stays busy after issue (1..7).
- FLUSH_EXTRA, 1, cycles flush is held after the redirect cycle (0..7).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- id_valid  in  NUM_WAYS  way j holds a valid instruction.
- id_rs  in  NUM_WAYS*REG_ADDR_W  source 1 per way, way j at [j*REG_ADDR_W +: REG_ADDR_W].
- id_rt  in  NUM_WAYS*REG_ADDR_W  source 2 per way.
- id_dst  in  NUM_WAYS*REG_ADDR_W  destination per way.
- id_wr_en  in  NUM_WAYS  way writes id_dst.
- id_is_load  in  NUM_WAYS  way is a load.
- id_oldest  in  $clog2(NUM_WAYS) (min 1)  index of oldest way; age increases modulo NUM_WAYS from it.
- way_busy  in  NUM_WAYS  structural busy per way.
- redirect  in  1  EX mispredict (taken or not-taken) or JR.
- pc_write  out  1  PC/IF advance enable.
- issue_ok  out  NUM_WAYS  way issues this cycle.
- hazard  out  NUM_WAYS  way valid but held.
- flush  out  NUM_WAYS  kill ID content of way.
- perf_stall_cnt  out  32  see Optional Feature.
- perf_flush_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): FSM=RUN, all scoreboard counters=0, flush_cnt=0, perf counters=0. Outputs follow combinational equations: pc_write=1, issue_ok=id_valid & ~way_busy-derived, flush=0.
- Scoreboard: one 3-bit counter per register; reg 0 is hardwired to 0.
  - On an issuing load with wr_en and dst!=0: counter[dst] <= LOAD_LAT at the next edge.
  - Otherwise every nonzero counter decrements by 1 per cycle.
  - Set wins over decrement. If two issuing loads share a dst, the value is still LOAD_LAT.
- own_haz[j] = valid[j] & (way_busy[j] | sb_busy(rs) | sb_busy(rt) | older-group RAW).
  - sb_busy(r) = (r!=0) & counter[r]!=0.
  - older-group RAW: any way i strictly older than j (age order from id_oldest) with valid, wr_en, dst!=0 and dst==rs[j] or dst==rt[j].
- In-order issue: issue_ok[j] = valid[j] & ~own_haz[j] & every valid older way issues. hazard[j] = valid[j] & ~issue_ok[j].
- pc_write = 1 iff no valid way is held.
- Latency: LOAD_LAT=1 gives the classic single-bubble load-use. The consumer in the next group issues one cycle late.
- FSM RUN:
  - redirect=1 → same cycle flush=all-ones, issue_ok=0, hazard=0, pc_write=1. Scoreboard is not cleared; older in-flight loads remain valid.
  - If FLUSH_EXTRA>0, go to FLUSH with flush_cnt=FLUSH_EXTRA-1.
- FSM FLUSH: flush=all-ones, issue_ok=0, hazard=0, pc_write=1, counters keep decrementing.
  - flush_cnt==0 → RUN.
  - redirect in FLUSH reloads flush_cnt=FLUSH_EXTRA-1 (stays FLUSH).
- Redirect has priority over every hazard and over way_busy.
- Loads that are flushed never set the scoreboard.
- id_oldest >= NUM_WAYS is treated as 0.

Optional Feature:
- Macro HDU_PERF_CNT_EN.
- Defined: perf_stall_cnt increments each RUN cycle with pc_write=0. perf_flush_cnt increments each cycle with any flush bit set. Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package hdu_pkg holds:
  - REG_ADDR_W default;
  - FSM state enum {RUN, FLUSH};
  - counter width constant SB_CNT_W=3;
  - age-rotation helper function (older(i,j,oldest)).
- Sub-module hdu_scoreboard holds the counter array, set/decrement logic and two read ports per way.

Test Plan:
- Load-use, NUM_WAYS=2, LOAD_LAT=1: cycle t way0 lw r5 issues; t+1 way0 add r6,r5,r1 → t+1 hazard[0]=1, pc_write=0; t+2 issue_ok[0]=1.
- Intra-group RAW, id_oldest=1: way1 writes r3, way0 reads r3 → issue_ok=2'b10, hazard=2'b01. With id_oldest=0, same registers → issue_ok=2'b01, hazard=2'b10.
- In-order block, NUM_WAYS=4: way_busy[1]=1, oldest=0, all valid, no RAW → issue_ok=4'b0001, hazard=4'b1110, pc_write=0.
- Redirect, FLUSH_EXTRA=2: redirect at t with active hazard → flush=all-ones at t, t+1, t+2; issue_ok=0; pc_write=1; RUN at t+3. A second redirect at t+1 extends flush through t+3.
- Reset mid-operation: LOAD_LAT=3, lw r7 issues, rst_n low 1 cycle after → counter cleared, FSM RUN. A reader of r7 after release is not held.
- HDU_PERF_CNT_EN defined: 5 stall cycles + 3 flush cycles → perf_stall_cnt=5, perf_flush_cnt=3. Undefined → both read 0.
